// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access at a time, issued to a word-wide memory port
// with byte enables, lane replication, load extension and an ack timeout.
module load_store_unit #(
  parameter  int NB_ADDR        = 32,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int NB_WORD        = 32,
  localparam int NB_FUNCT3      = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [NB_FUNCT3-1:0] i_funct3,
  input  logic [NB_ADDR-1:0]   i_address,
  input  logic [NB_WORD-1:0]   i_wr_data,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_error,
  output logic [NB_WORD-1:0]   o_read_data,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [3:0]           o_mem_be,
  output logic [NB_WORD-1:0]   o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [NB_WORD-1:0]   i_mem_rdata
);

  // state | meaning
  // IDLE  | ready to accept an access
  // REQ   | memory request outstanding, timeout counter running
  // DONE  | one-cycle completion pulse
  // ERR   | one-cycle completion pulse with error
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic [NB_ADDR-1:0]   mem_addr_q;
  logic [3:0]           be_q;
  logic [NB_WORD-1:0]   wdata_q;
  logic [NB_WORD-1:0]   read_data_q;

  logic                 legal_d;
  logic [3:0]           be_d;
  logic [NB_WORD-1:0]   wdata_d;
  logic [NB_WORD-1:0]   shifted;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [NB_WORD-1:0]   load_d;

  always_comb begin
    legal_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = i_wr_data;
    if (i_we) begin
      case (i_funct3)
        3'd0: begin
          legal_d = 1'b1;
          be_d    = 4'b0001 << i_address[1:0];
          wdata_d = {4{i_wr_data[7:0]}};
        end
        3'd1: begin
          legal_d = ~i_address[0];
          be_d    = 4'b0011 << i_address[1:0];
          wdata_d = {2{i_wr_data[15:0]}};
        end
        3'd2:    legal_d = (i_address[1:0] == 2'b00);
        default: legal_d = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        3'd0, 3'd4: legal_d = 1'b1;
        3'd1, 3'd5: legal_d = ~i_address[0];
        3'd2:       legal_d = (i_address[1:0] == 2'b00);
        default:    legal_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    shifted  = i_mem_rdata >> {off_q, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_d = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_d = {24'd0, byte_sel};
      3'd1:    load_d = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_d = {16'd0, half_sel};
      default: load_d = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_addr_q  <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req) begin
            we_q       <= i_we;
            funct3_q   <= i_funct3;
            off_q      <= i_address[1:0];
            mem_addr_q <= {i_address[NB_ADDR-1:2], 2'b00};
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= '0;
            if (legal_d) begin
              state_q <= REQ;
            end else begin
              state_q     <= ERR;
              read_data_q <= '0;
            end
          end
        end
        REQ: begin
          // an ack arriving in the last allowed cycle still completes normally
          if (i_mem_ack) begin
            read_data_q <= load_d;
            state_q     <= DONE;
          end else if (cnt_q == TC_LAST) begin
            read_data_q <= '0;
            state_q     <= ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_done      = (state_q == DONE) || (state_q == ERR);
  assign o_error     = (state_q == ERR);
  assign o_read_data = read_data_q;
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = (state_q == REQ) && we_q;
  assign o_mem_be    = (state_q == REQ) ? be_q : 4'b0000;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: NB_ADDR, 32, byte-address width; NB_WORD is fixed at 32 (riscv_defs).
REQ-002 Parameter: TIMEOUT_CYCLES, 16, maximum cycles in REQ awaiting i_mem_ack (range 1..255).
REQ-003 Port: i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: i_reset  input  1  synchronous, active-low reset; sampled on the i_clock rising edge.
REQ-005 Port: i_req  input  1  CPU access request; accepted only when o_ready=1.
REQ-006 Port: i_we  input  1  1=store, 0=load.
REQ-007 Port: i_funct3  input  NB_FUNCT3  F3_LB/LH/LW/LBU/LHU or F3_SB/SH/SW encoding.
REQ-008 Port: i_address  input  NB_ADDR  byte address.
REQ-009 Port: i_wr_data  input  NB_WORD  store data, LSB-justified.
REQ-010 Port: o_ready  output  1  high only in IDLE.
REQ-011 Port: o_done  output  1  one-cycle completion pulse.
REQ-012 Port: o_error  output  1  qualifies o_done; misaligned, illegal funct3, or timeout.
REQ-013 Port: o_read_data  output  NB_WORD  extended load result; valid while o_done=1.
REQ-014 Port: o_mem_req  output  1  memory request, held until acknowledged.
REQ-015 Port: o_mem_we  output  1  memory write enable.
REQ-016 Port: o_mem_addr  output  NB_ADDR  word address, {addr[NB_ADDR-1:2],2'b00}.
REQ-017 Port: o_mem_be  output  4  byte-lane enables.
REQ-018 Port: o_mem_wdata  output  NB_WORD  lane-replicated store data.
REQ-019 Port: i_mem_ack  input  1  memory completion; ignored outside REQ.
REQ-020 Port: i_mem_rdata  input  NB_WORD  full read word; valid with i_mem_ack.

Function
REQ-021 FSM states IDLE, REQ, DONE, ERR; i_req, i_we, i_funct3, i_address and i_wr_data are latched on acceptance (IDLE and i_req=1).
REQ-022 IDLE->REQ on accept if the access is legal; IDLE->ERR on accept if it is illegal; otherwise stay in IDLE.
REQ-023 Illegal access: halfword with addr[0]=1, word with addr[1:0]!=0, or load funct3 in {3,6,7}, or store funct3 >2.
REQ-024 REQ: o_mem_req=1 and all memory outputs stable; on i_mem_ack=1 capture the extracted data and go to DONE.
REQ-025 Timeout counter clears on entry to REQ and increments each REQ cycle without ack; if ack is absent for TIMEOUT_CYCLES cycles, go to ERR and drop o_mem_req.
REQ-026 An ack in the same cycle the counter reaches TIMEOUT_CYCLES wins: DONE, no error.
REQ-027 DONE: o_done=1, o_error=0, then IDLE; ERR: o_done=1, o_error=1, o_read_data=0, then IDLE.
REQ-028 Latency: accept at edge k, o_mem_req high in cycle k+1, ack in cycle k+1 -> o_done in cycle k+2; illegal access -> o_done/o_error in cycle k+1.
REQ-029 Byte enables, with off=addr[1:0]: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111; loads 4'b1111.
REQ-030 Write data: SB {4{byte}}; SH {2{half}}; SW word.
REQ-031 Load extraction: select byte or half at off; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-032 In states other than REQ: o_mem_req=0, o_mem_we=0, o_mem_be=0.
REQ-033 o_read_data holds its last value outside DONE/ERR.
REQ-034 All outputs are registered or decoded from registered state only; there is no combinational path from i_req to any memory output.

Reset
REQ-035 On i_reset=0 at a clock edge: state=IDLE, counter=0, latched registers=0, o_read_data=0, o_done=0, o_error=0, o_mem_req=0, o_mem_we=0, o_mem_be=0, o_mem_addr=0, o_mem_wdata=0; o_ready=1 after release.
REQ-036 Reset asserted while in REQ drops o_mem_req in the following cycle; a late i_mem_ack is ignored.

Verification
REQ-037 LB at 0x103, i_mem_rdata=0x80FF_1234, ack immediate -> o_mem_addr=0x100, o_mem_be=0xF, o_read_data=0xFFFF_FF80 at k+2.
REQ-038 SH at 0x202, i_wr_data=0x0000_ABCD -> o_mem_be=4'b1100, o_mem_wdata=0xABCD_ABCD, o_mem_we=1, o_done with o_error=0.
REQ-039 LW at 0x301 -> no o_mem_req ever, o_done=o_error=1 at k+1, o_read_data=0.
REQ-040 LHU at 0x400, TIMEOUT_CYCLES=4, no ack -> o_mem_req high 4 cycles, then o_done=o_error=1.
REQ-041 Ack in the 4th REQ cycle with TIMEOUT_CYCLES=4 -> o_done=1, o_error=0, correct data.
REQ-042 Reset in the 2nd REQ cycle -> o_mem_req=0 the next cycle, o_ready=1 after release, no o_done pulse.
